// File: rtl/knn_ctrl_if.sv
// -----------------------------------------------------------------------------
// knn_ctrl_if
// Bundles the kNN sequencer's control, memory and core-facing signals.
//   start, abort      : run control from the register bank
//   busy, done        : run status back to the register bank
//   test_addr,
//   data_addr,
//   mem_ren           : read port of the test/data point memories (1-cycle latency)
//   core_clr,
//   core_rst_dist,
//   core_en,
//   core_valid        : strobes into the distance unit / sorted neighbour list
//   res_valid,
//   res_tidx,
//   res_ready         : per-test-point result handshake
// Modport master is the sequencer side; slave is the environment side.
// -----------------------------------------------------------------------------
interface knn_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) ();
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] test_addr;
  logic [ADDR_W-1:0] data_addr;
  logic              mem_ren;
  logic              core_clr;
  logic              core_rst_dist;
  logic              core_en;
  logic              core_valid;
  logic              res_valid;
  logic [CNT_W-1:0]  res_tidx;
  logic              res_ready;

  modport master (
    input  start, abort, res_ready,
    output busy, done, test_addr, data_addr, mem_ren,
           core_clr, core_rst_dist, core_en, core_valid,
           res_valid, res_tidx
  );

  modport slave (
    output start, abort, res_ready,
    input  busy, done, test_addr, data_addr, mem_ren,
           core_clr, core_rst_dist, core_en, core_valid,
           res_valid, res_tidx
  );
endinterface

// File: rtl/knn_ctrl.sv
// -----------------------------------------------------------------------------
// knn_ctrl
// Sequencer for the kNN datapath. For every test point it clears the neighbour
// list, streams each data point's dimension words out of the test/data
// memories into the distance unit, commits each finished distance, and then
// offers a result strobe that waits for the consumer.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : knn_ctrl_if.master (control, memory read port, core strobes, result)
// -----------------------------------------------------------------------------
module knn_ctrl #(
  parameter int NBR_TESTP = 4,
  parameter int NBR_DATAP = 10,
  parameter int NBR_DIMS  = 2,
  parameter int ADDR_W    = 8,
  parameter int CNT_W     = 8
) (
  input  logic          clk,
  input  logic          rst,
  knn_ctrl_if.master    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_DRAIN,
    S_COMMIT,
    S_RESULT,
    S_FIN
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] K_LAST  = CNT_W'(NBR_DIMS - 1);
  localparam logic [CNT_W-1:0] D_LAST  = CNT_W'(NBR_DATAP - 1);
  localparam logic [CNT_W-1:0] T_LAST  = CNT_W'(NBR_TESTP - 1);
  localparam int unsigned      DIMS_U  = NBR_DIMS;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  t_q, t_d;
  logic [CNT_W-1:0]  d_q, d_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [ADDR_W-1:0] test_addr_q, test_addr_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic              core_en_q, core_en_d;
  logic              core_rst_dist_q, core_rst_dist_d;
  logic              mem_ren;

  assign mem_ren = (state_q == S_LOAD);

  // Next-state and counter logic. abort overrides everything, including start
  // in IDLE and res_ready in RESULT.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    d_d     = d_q;
    k_d     = k_q;
    if (bus.abort) begin
      state_d = S_IDLE;
      t_d     = '0;
      d_d     = '0;
      k_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) state_d = S_CLR;
        end
        S_CLR: begin
          d_d     = '0;
          k_d     = '0;
          state_d = S_LOAD;
        end
        S_LOAD: begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = S_DRAIN;
          end else begin
            k_d = k_q + CNT_ONE;
          end
        end
        S_DRAIN: begin
          state_d = S_COMMIT;
        end
        S_COMMIT: begin
          // Decision uses the pre-increment index: d_q is the point just committed.
          d_d     = d_q + CNT_ONE;
          state_d = (d_q < D_LAST) ? S_LOAD : S_RESULT;
        end
        S_RESULT: begin
          if (bus.res_ready) begin
            if (t_q < T_LAST) begin
              t_d     = t_q + CNT_ONE;
              state_d = S_CLR;
            end else begin
              state_d = S_FIN;
            end
          end
        end
        S_FIN: begin
          t_d     = '0;
          d_d     = '0;
          k_d     = '0;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Read data returns one cycle after mem_ren, so the core strobes are the
    // read strobe delayed by a flop; an abort suppresses the trailing strobe.
    core_en_d       = mem_ren & ~bus.abort;
    core_rst_dist_d = mem_ren & (k_q == '0) & ~bus.abort;

    // Addresses track the next counter values so the registered address is
    // always t*NBR_DIMS+k / d*NBR_DIMS+k for the current counters.
    test_addr_d = ADDR_W'(32'(t_d) * DIMS_U + 32'(k_d));
    data_addr_d = ADDR_W'(32'(d_d) * DIMS_U + 32'(k_d));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      t_q             <= '0;
      d_q             <= '0;
      k_q             <= '0;
      test_addr_q     <= '0;
      data_addr_q     <= '0;
      core_en_q       <= 1'b0;
      core_rst_dist_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      t_q             <= t_d;
      d_q             <= d_d;
      k_q             <= k_d;
      test_addr_q     <= test_addr_d;
      data_addr_q     <= data_addr_d;
      core_en_q       <= core_en_d;
      core_rst_dist_q <= core_rst_dist_d;
    end
  end

  // Strobes decode directly from the state register, so an asynchronous reset
  // drops them immediately.
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = (state_q == S_FIN);
  assign bus.mem_ren       = mem_ren;
  assign bus.core_clr      = (state_q == S_CLR);
  assign bus.core_valid    = (state_q == S_COMMIT);
  assign bus.res_valid     = (state_q == S_RESULT);
  assign bus.res_tidx      = t_q;
  assign bus.test_addr     = test_addr_q;
  assign bus.data_addr     = data_addr_q;
  assign bus.core_en       = core_en_q;
  assign bus.core_rst_dist = core_rst_dist_q;

endmodule

// File: tb/tb_knn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_knn_ctrl
// Self-checking bench for knn_ctrl. Two instances: defaults (4 test points,
// 10 data points, 2 dims) and a 1-dim / 3-data / 1-test variant. The expected
// cycle-by-cycle schedule is built from the sequencing rules (one clear cycle,
// NBR_DIMS+2 cycles per data point, result wait, one finish cycle) and compared
// against the observed outputs.
// -----------------------------------------------------------------------------
module tb_knn_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  knn_ctrl_if #(.ADDR_W(8), .CNT_W(8)) bus_a ();
  knn_ctrl_if #(.ADDR_W(8), .CNT_W(8)) bus_b ();

  knn_ctrl #(.NBR_TESTP(4), .NBR_DATAP(10), .NBR_DIMS(2), .ADDR_W(8), .CNT_W(8))
    u_a (.clk(clk), .rst(rst_n), .bus(bus_a));

  knn_ctrl #(.NBR_TESTP(1), .NBR_DATAP(3), .NBR_DIMS(1), .ADDR_W(8), .CNT_W(8))
    u_b (.clk(clk), .rst(rst_n), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  // Observed vector: [31]busy [30]done [29]mem_ren [28]core_clr [27]core_rst_dist
  // [26]core_en [25]core_valid [24]res_valid [23:16]res_tidx [15:8]test_addr [7:0]data_addr
  logic [31:0] obs_a, obs_b;
  assign obs_a = {bus_a.busy, bus_a.done, bus_a.mem_ren, bus_a.core_clr, bus_a.core_rst_dist,
                  bus_a.core_en, bus_a.core_valid, bus_a.res_valid, bus_a.res_tidx,
                  bus_a.test_addr, bus_a.data_addr};
  assign obs_b = {bus_b.busy, bus_b.done, bus_b.mem_ren, bus_b.core_clr, bus_b.core_rst_dist,
                  bus_b.core_en, bus_b.core_valid, bus_b.res_valid, bus_b.res_tidx,
                  bus_b.test_addr, bus_b.data_addr};

  typedef struct {
    logic [31:0] vec;
    bit          in_res;
    bit          rel;
    int          t;
    int          d;
    int          p;
  } rec_t;

  rec_t sched[$];
  int   stall[8];
  int   busy_cycles;
  int   abort_hit;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic s, input logic a, input logic r);
    if (sel) begin
      bus_b.start = s; bus_b.abort = a; bus_b.res_ready = r;
    end else begin
      bus_a.start = s; bus_a.abort = a; bus_a.res_ready = r;
    end
  endtask

  function automatic logic [31:0] get_obs(input bit sel);
    return sel ? obs_b : obs_a;
  endfunction

  // Addresses only matter while reading; res_tidx only while res_valid.
  function automatic logic [31:0] mask_vec(input logic [31:0] v, input logic [31:0] e);
    logic [31:0] r;
    r = v;
    if (!e[29]) r[15:0]  = '0;
    if (!e[24]) r[23:16] = '0;
    return r;
  endfunction

  function automatic rec_t mk(input logic [31:0] v, input bit in_res, input bit rel,
                              input int t, input int d, input int p);
    rec_t r;
    r.vec = v; r.in_res = in_res; r.rel = rel; r.t = t; r.d = d; r.p = p;
    return r;
  endfunction

  // Expected schedule of one run, starting with the cycle after start.
  task automatic build_sched(input int nt, input int nd, input int nk);
    logic [31:0] v;
    sched.delete();
    for (int t = 0; t < nt; t++) begin
      v = '0; v[31] = 1'b1; v[28] = 1'b1;
      sched.push_back(mk(v, 0, 0, t, -1, -1));
      for (int d = 0; d < nd; d++) begin
        for (int p = 0; p < nk + 2; p++) begin
          v = '0; v[31] = 1'b1;
          if (p < nk) begin
            v[29]    = 1'b1;
            v[15:8]  = 8'(t * nk + p);
            v[7:0]   = 8'(d * nk + p);
          end
          if (p >= 1 && p <= nk) v[26] = 1'b1;
          if (p == 1)            v[27] = 1'b1;
          if (p == nk + 1)       v[25] = 1'b1;
          sched.push_back(mk(v, 0, 0, t, d, p));
        end
      end
      for (int s = 0; s <= stall[t]; s++) begin
        v = '0; v[31] = 1'b1; v[24] = 1'b1; v[23:16] = 8'(t);
        sched.push_back(mk(v, 1, (s == stall[t]), t, -1, -1));
      end
    end
    v = '0; v[31] = 1'b1; v[30] = 1'b1;
    sched.push_back(mk(v, 0, 0, -1, -1, -1));
    sched.push_back(mk(32'h0, 0, 0, -1, -1, -1));
  endtask

  task automatic run_sched(input bit sel, input bit start_noise, input int abort_at,
                           input string tag);
    logic [31:0] o, e, raw;
    busy_cycles = 0;
    abort_hit   = 0;
    drive(sel, 1'b1, 1'b0, 1'b1);
    step();
    for (int i = 0; i < sched.size(); i++) begin
      e   = sched[i].vec;
      raw = get_obs(sel);
      o   = mask_vec(raw, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cycle %0d t=%0d d=%0d p=%0d: got %h expected %h",
                 tag, i, sched[i].t, sched[i].d, sched[i].p, o, e);
      end
      if (raw[31]) busy_cycles++;
      if (i == sched.size() - 1) break;
      drive(sel, start_noise ? 1'($urandom) : 1'b0, (i == abort_at),
            sched[i].in_res ? sched[i].rel : 1'($urandom));
      step();
      if (i == abort_at) begin
        abort_hit = 1;
        break;
      end
    end
    drive(sel, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    step();
    checks++;
    if (obs_a !== 32'h0) begin
      errors++; $display("FAIL reset_a: got %h expected %h", obs_a, 32'h0);
    end
    checks++;
    if (obs_b !== 32'h0) begin
      errors++; $display("FAIL reset_b: got %h expected %h", obs_b, 32'h0);
    end
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (obs_a !== 32'h0) begin
      errors++; $display("FAIL idle_after_reset: got %h expected %h", obs_a, 32'h0);
    end
  endtask

  task automatic test_full_run();
    for (int t = 0; t < 8; t++) stall[t] = 0;
    build_sched(4, 10, 2);
    run_sched(0, 0, -1, "full_run");
    checks++;
    if (busy_cycles !== 169) begin
      errors++; $display("FAIL busy_cycles: got %0d expected %0d", busy_cycles, 169);
    end
  endtask

  task automatic test_backpressure();
    for (int t = 0; t < 8; t++) stall[t] = $urandom_range(0, 3);
    stall[1] = 5;
    build_sched(4, 10, 2);
    run_sched(0, 0, -1, "backpressure");
  endtask

  task automatic test_start_during_busy();
    for (int t = 0; t < 8; t++) stall[t] = $urandom_range(0, 2);
    build_sched(4, 10, 2);
    run_sched(0, 1, -1, "start_busy");
  endtask

  task automatic test_abort();
    int idx;
    for (int t = 0; t < 8; t++) stall[t] = 0;
    build_sched(4, 10, 2);
    idx = -1;
    for (int i = 0; i < sched.size(); i++)
      if (sched[i].t == 0 && sched[i].d == 3 && sched[i].p == 1 && idx < 0) idx = i;
    run_sched(0, 0, idx, "abort_run");
    checks++;
    if (abort_hit !== 1) begin
      errors++; $display("FAIL abort_reached: got %0d expected %0d", abort_hit, 1);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (obs_a[31:24] !== 8'h00) begin
        errors++; $display("FAIL abort_idle c=%0d: got %h expected %h", c, obs_a[31:24], 8'h00);
      end
      step();
    end
    // start together with abort must not leave IDLE
    drive(0, 1'b1, 1'b1, 1'b0);
    step();
    drive(0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_a[31] !== 1'b0) begin
      errors++; $display("FAIL start_abort_busy: got %b expected %b", obs_a[31], 1'b0);
    end
    step();
    checks++;
    if (obs_a[31:24] !== 8'h00) begin
      errors++; $display("FAIL start_abort_idle: got %h expected %h", obs_a[31:24], 8'h00);
    end
    run_sched(0, 0, -1, "after_abort");
  endtask

  task automatic test_async_reset();
    drive(0, 1'b1, 1'b0, 1'b1);
    step();
    drive(0, 1'b0, 1'b0, 1'b1);
    repeat (4) step();
    checks++;
    if (obs_a[25] !== 1'b1) begin
      errors++; $display("FAIL commit_reached: got %b expected %b", obs_a[25], 1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_a !== 32'h0) begin
      errors++; $display("FAIL async_reset_now: got %h expected %h", obs_a, 32'h0);
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (obs_a !== 32'h0) begin
        errors++; $display("FAIL post_reset_idle c=%0d: got %h expected %h", c, obs_a, 32'h0);
      end
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_dims1();
    for (int t = 0; t < 8; t++) stall[t] = $urandom_range(0, 2);
    build_sched(1, 3, 1);
    run_sched(1, 0, -1, "dims1");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    test_reset();
    test_full_run();
    test_backpressure();
    test_start_during_busy();
    test_abort();
    test_async_reset();
    test_dims1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/knn_ctrl.md
Name: knn_ctrl

Overview:
- Sequencer for the kNN datapath (distance unit plus sorted nearest-neighbour list).
- For each test point it clears the list, streams every data point's dimension words from test/data memories into the distance unit, and commits each finished distance into the list.
- After the last data point it presents a per-test-point result strobe with backpressure.
- Sits between the register-bank start/status interface, the point memories and the kNN core.

Parameters:
- NBR_TESTP, 4, number of test points processed per run.
- NBR_DATAP, 10, number of reference data points per test point.
- NBR_DIMS, 2, words per point (one dimension per word).
- ADDR_W, 8, memory address width; must satisfy NBR_DATAP*NBR_DIMS <= 2^ADDR_W and NBR_TESTP*NBR_DIMS <= 2^ADDR_W.
- CNT_W, 8, width of the test/data/dimension counters and res_tidx.

Ports:
- clk, input, 1, system clock; all logic rising-edge.
- rst, input, 1, asynchronous active-low reset.
- start, input, 1, begin a run; sampled only in IDLE.
- abort, input, 1, synchronous abort to IDLE.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse when the run completes.
- test_addr, output, ADDR_W, test memory read address; memory has 1-cycle read latency.
- data_addr, output, ADDR_W, data memory read address; memory has 1-cycle read latency.
- mem_ren, output, 1, read enable for both memories.
- core_clr, output, 1, clears the neighbour list (core reset) for a new test point.
- core_rst_dist, output, 1, restarts the distance accumulator.
- core_en, output, 1, accumulate the current A/B word pair.
- core_valid, output, 1, commit the accumulated distance into the list.
- res_valid, output, 1, result for test point res_tidx is ready in the list.
- res_tidx, output, CNT_W, index of the finished test point.
- res_ready, input, 1, consumer has taken the result.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; all counters clear to 0.
  - busy, done, mem_ren, core_clr, core_rst_dist, core_en, core_valid and res_valid are 0.
  - test_addr, data_addr and res_tidx are 0.
- Counters: t (test point), d (data point), k (dimension).
- Addresses: test_addr = t*NBR_DIMS+k and data_addr = d*NBR_DIMS+k, registered.
- States and transitions:
  - IDLE: start=1 -> CLR. start is ignored in every other state.
  - CLR (1 cycle): core_clr=1; d=0, k=0 -> LOAD.
  - LOAD (NBR_DIMS cycles): mem_ren=1 with the current addresses; k increments each cycle. When k=NBR_DIMS-1: k clears -> DRAIN.
  - DRAIN (1 cycle): issues no read; covers the last read's latency.
  - COMMIT (1 cycle): core_valid=1. Then d increments; if d<NBR_DATAP-1 -> LOAD, else -> RESULT.
  - RESULT: res_valid=1, res_tidx=t; held until res_ready=1, which must be sampled in this state.
    - If t<NBR_TESTP-1: t increments -> CLR.
    - Otherwise -> FIN.
  - FIN (1 cycle): done=1; counters clear -> IDLE.
- Read-data alignment:
  - core_en is mem_ren delayed by one cycle, so it is high for exactly NBR_DIMS cycles per data point: the last LOAD cycles plus DRAIN.
  - core_rst_dist is high together with the first core_en of each data point. The distance unit loads rather than accumulates on that cycle.
- Timing per data point is NBR_DIMS+2 cycles. Per test point it is 1 + NBR_DATAP*(NBR_DIMS+2) cycles plus the RESULT wait; RESULT takes at least 1 cycle.
- res_valid and res_tidx must stay stable while res_ready=0. res_ready outside RESULT is ignored.
- abort=1 in any state:
  - Next state is IDLE; counters clear.
  - All strobes go low on the next edge; done is not pulsed.
  - abort has priority over start, and over res_ready in RESULT.
- Simultaneous start and abort in IDLE: the block stays in IDLE.
- Async reset mid-run behaves as abort, immediately; no partial result is presented.
- NBR_DIMS=1: LOAD lasts 1 cycle, and core_en and core_rst_dist coincide.

Test Plan:
- Defaults, start pulse, res_ready tied 1:
  - First core_clr comes 1 cycle after start.
  - Each data point gives 4 cycles: core_en high 2 cycles, then core_valid 1 cycle.
  - 4 res_valid pulses with res_tidx 0,1,2,3; done exactly 1 cycle after the last result.
  - busy low again after 4*(1+40+1)+1 = 169 cycles.
- Address check:
  - For t=2, d=7, reads are test_addr 4,5 and data_addr 14,15.
  - core_rst_dist is aligned with the first core_en of each pair.
- Backpressure: hold res_ready=0 for 5 cycles on t=1 -> res_valid and res_tidx=1 stay stable; no core_clr and no reads until res_ready=1.
- Abort at d=3, k=1 of t=0 -> next cycle IDLE, busy=0, no core_valid, no done; a new start restarts at t=0 with test_addr 0.
- Async reset asserted during COMMIT -> all outputs 0 immediately (before the next clock edge).
- start during busy -> no effect on counters or sequence.
- NBR_DIMS=1, NBR_DATAP=3, NBR_TESTP=1:
  - core_en and core_rst_dist high together for 1 cycle per data point.
  - 3 core_valid pulses, then 1 res_valid with res_tidx=0.
